eth_tx_ptp_stream_arbiter: RTL
==============================

Name: eth_tx_ptp_stream_arbiter

Overview:
Packet-level arbiter that shares one MAC TX Avalon-ST port between two TX DMA streams, for example a PTP/event queue and a bulk queue. The grant is locked for a whole packet (SOP..EOP). On every accepted SOP it issues a timestamp request with a fingerprint of the form {source_id, per-source sequence}. A registered copy of the fingerprint goes out on an AVST side channel so the TX timestamp collector can route the returned timestamp to the correct DMA. The block sits between the two TX DMA sources and the MAC TX client interface.

Parameters:
- DATA_WIDTH, 64, data bus width (BITSPERSYMBOL*SYMBOLSPERBEAT).
- EMPTY_WIDTH, 3, width of the empty field.
- ERROR_WIDTH, 6, width of the error field.
- TIMEOUT_CYCLES, 1024, mid-packet stall limit. Used only with the optional feature.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- asi_in0_{sop,eop,valid}  in  1 each  sink 0 (high-priority-start source) control
- asi_in0_ready  out  1  sink 0 ready
- asi_in0_data  in  DATA_WIDTH
- asi_in0_empty  in  EMPTY_WIDTH
- asi_in0_error  in  ERROR_WIDTH
- asi_in1_*  same set as asi_in0_*  sink 1
- aso_out_{sop,eop,valid}  out  1 each  source to MAC
- aso_out_ready  in  1  MAC ready
- aso_out_data  out  DATA_WIDTH
- aso_out_empty  out  EMPTY_WIDTH
- aso_out_error  out  ERROR_WIDTH
- tstamp_req_valid  out  1  timestamp request strobe
- tstamp_req_fingerprint  out  8  {src, seq[6:0]}
- aso_fingerprint_valid  out  1  side-channel fingerprint valid
- aso_fingerprint  out  8  side-channel fingerprint
- aso_fingerprint_ready  in  1  side-channel ready
- fp_overrun  out  1  sticky flag: fingerprint overwritten before it was consumed
- orphan_cnt  out  16  saturating count of discarded non-SOP beats in IDLE

Behaviour:
- States: IDLE, PKT0, PKT1, plus ABORT and DRAIN (feature only). Reset → IDLE.
- Reset values: rr_last=1 (sink 0 wins the first tie), seq0=seq1=0, aso_fingerprint=0, aso_fingerprint_valid=0, fp_overrun=0, orphan_cnt=0.
- IDLE:
  - aso_out_valid=0.
  - Candidate n = asi_inN_valid & asi_inN_sop. If both are candidates, grant the source != rr_last. Else grant the single candidate.
  - On grant: next state PKTn, rr_last<=n. asi_inN_ready=0 in IDLE for candidates, so the SOP beat is held by the source.
  - A source that is valid without SOP in IDLE sees ready=1 and its beat is discarded. orphan_cnt +1, saturating at 0xFFFF. If both sources are orphans in the same cycle, increment by 2, saturating.
  - Grant costs one bubble cycle per packet.
- PKTn:
  - Output fields are combinationally equal to sink n. asi_inN_ready=aso_out_ready. The other sink's ready=0.
  - Beat accepted = aso_out_valid & aso_out_ready.
  - Accepted beat with eop → IDLE. A single-beat packet (sop&eop) returns to IDLE after 1 beat.
  - An SOP seen mid-packet is passed through unchanged. No check is made.
- Timestamp request:
  - tstamp_req_valid = accepted beat & aso_out_sop. Combinational, same cycle as the beat.
  - tstamp_req_fingerprint = {n, seqN}, also combinational.
  - On that cycle: seqN<=seqN+1, wrapping 127→0.
  - On that cycle: aso_fingerprint<={n,seqN}, aso_fingerprint_valid<=1.
- Side channel:
  - aso_fingerprint_valid clears on aso_fingerprint_ready when no new SOP is accepted in that cycle.
  - New SOP with valid=1 and ready=0: the register is overwritten and fp_overrun<=1 (sticky until reset).
  - New SOP with ready=1 in the same cycle: the new value loads and valid stays 1.
- Reset mid-packet: return immediately to IDLE; all outputs take their reset values next cycle.

Optional Feature:
- Macro ETH_TX_ARB_PKT_TIMEOUT_EN.
- Defined:
  - In PKTn, a 16-bit stall counter increments each cycle sink n is not valid, and resets on any sink n valid.
  - When the counter reaches TIMEOUT_CYCLES, enter ABORT.
  - ABORT drives one synthetic beat: valid=1, sop=0, eop=1, data=0, empty=0, error=all-ones. It holds until aso_out_ready, then goes to DRAIN.
  - DRAIN sets asi_inN_ready=1 and aso_out_valid=0, discards beats until an eop beat from sink n is accepted, then → IDLE.
  - Adds output timeout_cnt [15:0], saturating.
- Not defined: no counter, no ABORT/DRAIN, no timeout_cnt port. A stalled source holds the grant indefinitely.

Test Plan:
- Both sinks present a 3-beat packet at reset release → out carries sink0 packet, then sink1. Fingerprints are 0x00 then 0x80. Exactly one bubble before each SOP.
- Sink1 streams 130 single-beat packets with sink0 idle → fingerprints run 0x80..0xFF, then wrap to 0x80, 0x81. tstamp_req_valid pulses 130 times.
- aso_out_ready toggles 1/0 during a 4-beat packet on sink0 → all 4 beats are delivered in order. tstamp_req_valid is high only on the SOP acceptance cycle. Sink1 ready stays 0 throughout.
- aso_fingerprint_ready held 0 across two packets → aso_fingerprint equals the second fingerprint and fp_overrun=1. Asserting ready for one cycle → aso_fingerprint_valid=0.
- Sink0 valid without SOP for 5 beats in IDLE → orphan_cnt=5 and no output beats.
- With ETH_TX_ARB_PKT_TIMEOUT_EN and TIMEOUT_CYCLES=8, sink0 stalls after beat 2 → synthetic eop beat with error=6'h3F. The late remainder of the packet is drained, timeout_cnt=1, then sink1 is granted.

Source files
------------

// File: rtl/eth_tx_ptp_stream_arbiter.sv
// Packet-level arbiter sharing one MAC TX Avalon-ST port between two TX DMA streams.
// The grant is held from SOP to EOP. Every accepted SOP raises a timestamp request
// tagged {source, per-source sequence}. A registered copy of that tag is offered on an
// AVST side channel for the TX timestamp collector.
//
// Ports:
//   clock, reset           : clock and synchronous active-high reset
//   asi_in0_* / asi_in1_*  : two Avalon-ST sinks (sop/eop/valid/ready/data/empty/error)
//   aso_out_*              : Avalon-ST source towards the MAC
//   tstamp_req_valid/_fingerprint : combinational timestamp request on SOP acceptance
//   aso_fingerprint_valid/_ready, aso_fingerprint : registered fingerprint side channel
//   fp_overrun             : sticky, set when an unconsumed fingerprint is overwritten
//   orphan_cnt             : saturating count of non-SOP beats discarded while idle
//   timeout_cnt            : saturating count of aborted packets (timeout build only)
//
// Optional feature macro: ETH_TX_ARB_PKT_TIMEOUT_EN. When it is defined, a mid-packet
// stall of TIMEOUT_CYCLES aborts the packet with a synthetic errored EOP beat and then
// drains the rest of the packet from the stalled source.
module eth_tx_ptp_stream_arbiter #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned EMPTY_WIDTH    = 3,
  parameter int unsigned ERROR_WIDTH    = 6,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   asi_in0_sop,
  input  logic                   asi_in0_eop,
  input  logic                   asi_in0_valid,
  output logic                   asi_in0_ready,
  input  logic [DATA_WIDTH-1:0]  asi_in0_data,
  input  logic [EMPTY_WIDTH-1:0] asi_in0_empty,
  input  logic [ERROR_WIDTH-1:0] asi_in0_error,
  input  logic                   asi_in1_sop,
  input  logic                   asi_in1_eop,
  input  logic                   asi_in1_valid,
  output logic                   asi_in1_ready,
  input  logic [DATA_WIDTH-1:0]  asi_in1_data,
  input  logic [EMPTY_WIDTH-1:0] asi_in1_empty,
  input  logic [ERROR_WIDTH-1:0] asi_in1_error,
  output logic                   aso_out_sop,
  output logic                   aso_out_eop,
  output logic                   aso_out_valid,
  input  logic                   aso_out_ready,
  output logic [DATA_WIDTH-1:0]  aso_out_data,
  output logic [EMPTY_WIDTH-1:0] aso_out_empty,
  output logic [ERROR_WIDTH-1:0] aso_out_error,
  output logic                   tstamp_req_valid,
  output logic [7:0]             tstamp_req_fingerprint,
  output logic                   aso_fingerprint_valid,
  output logic [7:0]             aso_fingerprint,
  input  logic                   aso_fingerprint_ready,
  output logic                   fp_overrun,
`ifdef ETH_TX_ARB_PKT_TIMEOUT_EN
  output logic [15:0]            timeout_cnt,
`endif
  output logic [15:0]            orphan_cnt
);

  // The stall counter is 16 bits wide, so the limit must fit.
  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StPkt0  = 3'd1;
  localparam logic [2:0] StPkt1  = 3'd2;
`ifdef ETH_TX_ARB_PKT_TIMEOUT_EN
  localparam logic [2:0] StAbort = 3'd3;
  localparam logic [2:0] StDrain = 3'd4;
  localparam logic [15:0] StallLimit = 16'(TIMEOUT_CYCLES - 1);
`endif

  logic [2:0]  r_state;
  logic [2:0]  w_state_d;
  logic        r_rr_last;
  logic        r_src;          // source that owns (or last owned) the grant
  logic [6:0]  r_seq0;
  logic [6:0]  r_seq1;
  logic [7:0]  r_fp;
  logic        r_fp_valid;
  logic        r_fp_overrun;
  logic [15:0] r_orphan_cnt;

  logic                   w_cand0;
  logic                   w_cand1;
  logic                   w_grant_src;
  logic                   w_in_pkt;
  logic                   w_accept;
  logic                   w_sel_valid;
  logic                   w_sel_sop;
  logic                   w_sel_eop;
  logic [DATA_WIDTH-1:0]  w_sel_data;
  logic [EMPTY_WIDTH-1:0] w_sel_empty;
  logic [ERROR_WIDTH-1:0] w_sel_error;
  logic [1:0]             w_orphan_inc;
  logic [16:0]            w_orphan_sum;

`ifdef ETH_TX_ARB_PKT_TIMEOUT_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_timeout_cnt;
  logic        w_stall_hit;
  assign w_stall_hit = w_in_pkt & ~w_sel_valid & (r_stall_cnt == StallLimit);
  assign timeout_cnt = r_timeout_cnt;
`endif

  assign w_cand0     = asi_in0_valid & asi_in0_sop;
  assign w_cand1     = asi_in1_valid & asi_in1_sop;
  // On a tie the source that did not win last time is granted.
  assign w_grant_src = (w_cand0 & w_cand1) ? ~r_rr_last : w_cand1;
  assign w_in_pkt    = (r_state == StPkt0) || (r_state == StPkt1);

  assign w_sel_valid = r_src ? asi_in1_valid : asi_in0_valid;
  assign w_sel_sop   = r_src ? asi_in1_sop   : asi_in0_sop;
  assign w_sel_eop   = r_src ? asi_in1_eop   : asi_in0_eop;
  assign w_sel_data  = r_src ? asi_in1_data  : asi_in0_data;
  assign w_sel_empty = r_src ? asi_in1_empty : asi_in0_empty;
  assign w_sel_error = r_src ? asi_in1_error : asi_in0_error;

  // Datapath and ready steering.
  always_comb begin
    aso_out_valid = 1'b0;
    aso_out_sop   = 1'b0;
    aso_out_eop   = 1'b0;
    aso_out_data  = '0;
    aso_out_empty = '0;
    aso_out_error = '0;
    asi_in0_ready = 1'b0;
    asi_in1_ready = 1'b0;
    case (r_state)
      StIdle: begin
        // SOP beats are held for the grant; non-SOP beats are accepted and dropped.
        asi_in0_ready = ~asi_in0_sop;
        asi_in1_ready = ~asi_in1_sop;
      end
      StPkt0, StPkt1: begin
        aso_out_valid = w_sel_valid;
        aso_out_sop   = w_sel_sop;
        aso_out_eop   = w_sel_eop;
        aso_out_data  = w_sel_data;
        aso_out_empty = w_sel_empty;
        aso_out_error = w_sel_error;
        if (r_src) asi_in1_ready = aso_out_ready;
        else       asi_in0_ready = aso_out_ready;
      end
`ifdef ETH_TX_ARB_PKT_TIMEOUT_EN
      StAbort: begin
        aso_out_valid = 1'b1;
        aso_out_eop   = 1'b1;
        aso_out_error = '1;
      end
      StDrain: begin
        if (r_src) asi_in1_ready = 1'b1;
        else       asi_in0_ready = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign w_accept               = aso_out_valid & aso_out_ready;
  assign tstamp_req_valid       = w_accept & aso_out_sop;
  assign tstamp_req_fingerprint = {r_src, (r_src ? r_seq1 : r_seq0)};

  assign w_orphan_inc = {1'b0, asi_in0_valid & ~asi_in0_sop} +
                        {1'b0, asi_in1_valid & ~asi_in1_sop};
  assign w_orphan_sum = {1'b0, r_orphan_cnt} + {15'd0, w_orphan_inc};

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (w_cand0 | w_cand1) w_state_d = w_grant_src ? StPkt1 : StPkt0;
      end
      StPkt0, StPkt1: begin
        if (w_accept & aso_out_eop) w_state_d = StIdle;
`ifdef ETH_TX_ARB_PKT_TIMEOUT_EN
        else if (w_stall_hit) w_state_d = StAbort;
`endif
      end
`ifdef ETH_TX_ARB_PKT_TIMEOUT_EN
      StAbort: begin
        if (aso_out_ready) w_state_d = StDrain;
      end
      StDrain: begin
        if (w_sel_valid & w_sel_eop) w_state_d = StIdle;
      end
`endif
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= StIdle;
      r_rr_last    <= 1'b1;
      r_src        <= 1'b0;
      r_seq0       <= '0;
      r_seq1       <= '0;
      r_fp         <= '0;
      r_fp_valid   <= 1'b0;
      r_fp_overrun <= 1'b0;
      r_orphan_cnt <= '0;
`ifdef ETH_TX_ARB_PKT_TIMEOUT_EN
      r_stall_cnt   <= '0;
      r_timeout_cnt <= '0;
`endif
    end else begin
      r_state <= w_state_d;
      if (r_state == StIdle) begin
        r_orphan_cnt <= w_orphan_sum[16] ? 16'hFFFF : w_orphan_sum[15:0];
        if (w_cand0 | w_cand1) begin
          r_rr_last <= w_grant_src;
          r_src     <= w_grant_src;
        end
      end
      if (tstamp_req_valid) begin
        if (r_src) r_seq1 <= r_seq1 + 7'd1;
        else       r_seq0 <= r_seq0 + 7'd1;
        r_fp       <= tstamp_req_fingerprint;
        r_fp_valid <= 1'b1;
        if (r_fp_valid & ~aso_fingerprint_ready) r_fp_overrun <= 1'b1;
      end else if (aso_fingerprint_ready) begin
        r_fp_valid <= 1'b0;
      end
`ifdef ETH_TX_ARB_PKT_TIMEOUT_EN
      if (w_in_pkt & ~w_sel_valid) r_stall_cnt <= r_stall_cnt + 16'd1;
      else                         r_stall_cnt <= '0;
      if (w_stall_hit && r_timeout_cnt != 16'hFFFF) r_timeout_cnt <= r_timeout_cnt + 16'd1;
`endif
    end
  end

  assign aso_fingerprint_valid = r_fp_valid;
  assign aso_fingerprint       = r_fp;
  assign fp_overrun            = r_fp_overrun;
  assign orphan_cnt            = r_orphan_cnt;

endmodule
